pipe_delay_line: RTL and testbench
==================================

// Module: pipe_delay_line
// PURPOSE
// Parametrised shift-register delay line with per-stage valid tracking, used to carry
// side-band fields (e.g. rd index, control bits) alongside the 5-stage RISC-V datapath.
// Generalises the fixed 2-bit x 5-stage delay with width/depth parameters, stall (hold),
// flush (kill), a run-time selectable tap and an occupancy counter.
// Sits between hazard/control logic (stall, flush) and the stage that consumes the field.
// PARAMETERS
// WIDTH        2  data bits per stage (>=1)
// DEPTH        5  number of register stages = latency in unstalled cycles (>=1)
// ZERO_INVALID 1  1: bubble/flushed stages hold data 0; 0: data shifts unqualified
// TAP_W        derived, = (DEPTH>1) ? $clog2(DEPTH) : 1 (localparam, not overridable)
// CNT_W        derived, = $clog2(DEPTH+1) (localparam)
// PORTS
// clk        in   1        rising-edge clock
// reset      in   1        asynchronous, active-low reset
// in_valid   in   1        in_data is valid this cycle
// in_data    in   WIDTH    data entering stage 0
// stall      in   1        1: every stage holds, input ignored
// flush      in   1        1: invalidate every stage (priority over stall)
// tap_sel    in   TAP_W    stage index observed on tap_* (0 = first stage)
// out_valid  out  1        valid bit of stage DEPTH-1
// out_data   out  WIDTH    data of stage DEPTH-1
// tap_valid  out  1        valid of stage tap_sel (comb. mux of registers)
// tap_data   out  WIDTH    data of stage tap_sel
// occupancy  out  CNT_W    number of valid stages (registered)
// BEHAVIOUR
// - reset low: all stage data, valid bits, occupancy -> 0 immediately; out_* = 0.
// - Priority per rising edge: flush > stall > advance.
// - flush=1: all valid <= 0; data <= 0 if ZERO_INVALID else held; occupancy <= 0;
//   in_valid in same cycle is dropped.
// - stall=1 (flush=0): all stages and occupancy hold; in_* ignored (not buffered).
// - advance: v[0]<=in_valid, d[0]<=(ZERO_INVALID && !in_valid)?0:in_data;
//   v[k]<=v[k-1], d[k]<=d[k-1] for k=1..DEPTH-1.
// - Latency: value presented with in_valid at edge N appears on out_* after edge N+DEPTH-1
//   (i.e. DEPTH advancing edges incl. capture); each stall cycle adds exactly one.
// - occupancy on advance: occ + in_valid - v[DEPTH-1]; never exceeds DEPTH, never wraps;
//   invariant occupancy == popcount(v) every cycle (assert in sim).
// - tap: tap_sel < DEPTH -> {v,d}[tap_sel]; tap_sel >= DEPTH -> tap_valid=0, tap_data=0.
//   Combinational from registers and tap_sel only; no path from in_* to any output.
// - DEPTH=1: single register, tap_sel bit ignored beyond index 0 rule above.
// - Reset deassertion mid-stream: pipeline restarts empty; first valid captured on the
//   first edge with reset high.
// TESTING  (WIDTH=2, DEPTH=5, ZERO_INVALID=1 unless noted)
// 1 reset, drive in_valid=1 data 1,2,3,0,1,2 on consecutive edges -> out_valid rises
//   5 edges after first capture, out_data 1,2,3,0,1,2; occupancy ramps 1..5, holds 5.
// 2 push data=3, then stall=1 for 3 cycles, then release -> out_data=3 appears after
//   5+3 edges; occupancy and all stages frozen during stall.
// 3 fill with 5 valids, assert flush with stall=1 and in_valid=1 -> next cycle
//   occupancy=0, out_valid=0, tap_valid=0 for all tap_sel, tap_data=0.
// 4 alternating in_valid 1/0 data 2 -> out_valid toggles 1/0, invalid slots data 0;
//   repeat with ZERO_INVALID=0 -> invalid slots carry shifted in_data.
// 5 sweep tap_sel 0..7 on known contents -> tap_* match stage k for k<5, zero for 5..7.
// 6 assert reset low mid-stream (async, between edges) -> outputs 0 without clock edge;
//   release, push data 1 -> out_data=1 after 5 edges. Also run WIDTH=32, DEPTH=1.

Source files
------------

// File: rtl/pipe_delay_line_if.sv
// Bundle of the delay-line data/control signals. The block that owns the
// stall/flush decisions and the input field uses the master side; the delay
// line itself uses the slave side.
interface pipe_delay_line_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 5
);
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             stall;
    logic             flush;
    logic [TAP_W-1:0] tap_sel;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             tap_valid;
    logic [WIDTH-1:0] tap_data;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output in_valid, in_data, stall, flush, tap_sel,
        input  out_valid, out_data, tap_valid, tap_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, stall, flush, tap_sel,
        output out_valid, out_data, tap_valid, tap_data, occupancy
    );
endinterface

// File: rtl/pipe_delay_line.sv
// Parametrised delay line carrying a side-band field alongside the pipeline.
// Each stage has its own valid bit; the line can be frozen (stall), emptied
// (flush, wins over stall) and probed at any stage through a run-time tap.
// A registered occupancy count tracks how many stages hold valid entries.
module pipe_delay_line #(
    parameter int WIDTH        = 2,
    parameter int DEPTH        = 5,
    parameter bit ZERO_INVALID = 1'b1
) (
    input logic              clk_i,
    input logic              reset_ni,
    pipe_delay_line_if.slave bus
);
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    logic             tap_vld;
    logic [WIDTH-1:0] tap_dat;

    // Occupancy after an advancing edge: one entry may come in at stage 0 and
    // one may leave from the last stage. Clamped to 0..DEPTH so a corrupted
    // count can never wrap.
    function automatic logic [CNT_W-1:0] occ_advance(
        input logic [CNT_W-1:0] occ,
        input logic             enter,
        input logic             leave
    );
        int n;
        n = int'(occ) + (enter ? 1 : 0) - (leave ? 1 : 0);
        if (n < 0)     n = 0;
        if (n > DEPTH) n = DEPTH;
        return CNT_W'(n);
    endfunction

    // Value written into stage 0: bubbles are scrubbed to zero when requested,
    // so downstream consumers never see stale field contents on invalid slots.
    function automatic logic [WIDTH-1:0] stage0_data(
        input logic             valid,
        input logic [WIDTH-1:0] data
    );
        if (ZERO_INVALID && !valid) return '0;
        return data;
    endfunction

    // Next-state selection per edge: flush beats stall, stall beats advance.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        occ_d  = occ_q;
        if (bus.flush) begin
            vld_d = '0;
            occ_d = '0;
            if (ZERO_INVALID) begin
                for (int k = 0; k < DEPTH; k++) begin
                    data_d[k] = '0;
                end
            end
        end else if (!bus.stall) begin
            vld_d[0]  = bus.in_valid;
            data_d[0] = stage0_data(bus.in_valid, bus.in_data);
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = data_q[k-1];
            end
            occ_d = occ_advance(occ_q, bus.in_valid, vld_q[DEPTH-1]);
        end
    end

    // Stage registers and occupancy; reset empties the line immediately.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            occ_q  <= occ_d;
            data_q <= data_d;
        end
    end

    // Tap mux: purely from stage registers and tap_sel; an index past the last
    // stage reads as an empty slot.
    always_comb begin
        tap_vld = 1'b0;
        tap_dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (bus.tap_sel == TAP_W'(k)) begin
                tap_vld = vld_q[k];
                tap_dat = data_q[k];
            end
        end
    end

    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.tap_valid = tap_vld;
    assign bus.tap_data  = tap_dat;
    assign bus.occupancy = occ_q;

    // The count must always equal the number of valid stages.
    occ_matches_valids: assert property (
        @(posedge clk_i) disable iff (!reset_ni)
        occ_q == CNT_W'($countones(vld_q))
    );

    // The count can never exceed the number of stages.
    occ_bounded: assert property (
        @(posedge clk_i) disable iff (!reset_ni)
        int'(occ_q) <= DEPTH
    );
endmodule

// File: tb/tb_pipe_delay_line.sv
// Bench for pipe_delay_line: three instances (2x5 scrubbing bubbles, 2x5
// unqualified data, 32x1) share control stimulus. An age-based reference model
// and per-instance expected-output queues are checked by a negedge monitor;
// directed sequences add hand-computed checks.
`timescale 1ns/1ps
module tb_pipe_delay_line;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [1:0]  in_data;
    logic [31:0] in_data_c;
    logic        stall;
    logic        flush;
    logic [2:0]  tap_sel;
    logic        tap_sel_c;
    bit          started = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_delay_line_if #(.WIDTH(2),  .DEPTH(5)) bus_a ();
    pipe_delay_line_if #(.WIDTH(2),  .DEPTH(5)) bus_b ();
    pipe_delay_line_if #(.WIDTH(32), .DEPTH(1)) bus_c ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_data  = in_data;
    assign bus_a.stall    = stall;
    assign bus_a.flush    = flush;
    assign bus_a.tap_sel  = tap_sel;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_data  = in_data;
    assign bus_b.stall    = stall;
    assign bus_b.flush    = flush;
    assign bus_b.tap_sel  = tap_sel;
    assign bus_c.in_valid = in_valid;
    assign bus_c.in_data  = in_data_c;
    assign bus_c.stall    = stall;
    assign bus_c.flush    = flush;
    assign bus_c.tap_sel  = tap_sel_c;

    pipe_delay_line #(.WIDTH(2), .DEPTH(5), .ZERO_INVALID(1'b1)) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .bus(bus_a));
    pipe_delay_line #(.WIDTH(2), .DEPTH(5), .ZERO_INVALID(1'b0)) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .bus(bus_b));
    pipe_delay_line #(.WIDTH(32), .DEPTH(1), .ZERO_INVALID(1'b1)) dut_c (
        .clk_i(clk), .reset_ni(reset_n), .bus(bus_c));

    // Reference model: every slot that entered the line is a record with an
    // age = number of advancing edges since it was captured. Age k+1 sits in
    // stage k; records older than the depth have left the line.
    typedef struct {
        int          id;
        bit          v;
        logic [31:0] d;
        int          age;
    } rec_t;

    rec_t        recs[$];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];
    bit          adv_last = 1'b0;

    function automatic int depth_of(input int id);
        return (id == 2) ? 1 : 5;
    endfunction

    function automatic bit zi_of(input int id);
        return id != 1;
    endfunction

    function automatic void push_exp(input int id, input logic [31:0] d);
        case (id)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            default: exp_q2.push_back(d);
        endcase
    endfunction

    function automatic int exp_size(input int id);
        case (id)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [31:0] pop_exp(input int id);
        case (id)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic void model_clear();
        recs.delete();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        adv_last = 1'b0;
    endfunction

    function automatic logic [32:0] stage_of(input int id, input int k);
        logic [32:0] r;
        r = '0;
        foreach (recs[i]) begin
            if (recs[i].id == id && recs[i].age == k + 1) r = {recs[i].v, recs[i].d};
        end
        return r;
    endfunction

    function automatic int occ_of(input int id);
        int n;
        n = 0;
        foreach (recs[i]) begin
            if (recs[i].id == id && recs[i].v) n++;
        end
        return n;
    endfunction

    // Apply one clock edge's worth of inputs to the model.
    function automatic void model_edge(input bit v, input logic [1:0] d,
                                       input logic [31:0] dc, input bit st, input bit fl);
        adv_last = !fl && !st;
        if (fl) begin
            foreach (recs[i]) begin
                recs[i].v = 1'b0;
                if (zi_of(recs[i].id)) recs[i].d = '0;
            end
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
        end else if (!st) begin
            for (int i = recs.size() - 1; i >= 0; i--) begin
                recs[i].age = recs[i].age + 1;
                if (recs[i].age > depth_of(recs[i].id)) recs.delete(i);
            end
            for (int id = 0; id < 3; id++) begin
                rec_t r;
                r.id  = id;
                r.v   = v;
                r.age = 1;
                r.d   = (id == 2) ? dc : {30'd0, d};
                if (zi_of(id) && !v) r.d = '0;
                recs.push_back(r);
                if (v) push_exp(id, r.d);
            end
        end
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_check(input int id, input logic ov, input logic [31:0] od, input int occ,
                             input int tap, input logic tv, input logic [31:0] td);
        logic [32:0] s;
        logic [32:0] t;
        logic [31:0] e;
        s = stage_of(id, depth_of(id) - 1);
        t = (tap < depth_of(id)) ? stage_of(id, tap) : 33'd0;
        check($sformatf("d%0d_out_valid", id), 33'(ov), 33'(s[32]));
        check($sformatf("d%0d_out_data", id), 33'(od), {1'b0, s[31:0]});
        check($sformatf("d%0d_occupancy", id), 33'(occ), 33'(occ_of(id)));
        check($sformatf("d%0d_tap_valid", id), 33'(tv), 33'(t[32]));
        check($sformatf("d%0d_tap_data", id), 33'(td), {1'b0, t[31:0]});
        if (adv_last && ov) begin
            if (exp_size(id) == 0) begin
                check($sformatf("d%0d_sb_unexpected_output", id), 33'(1), 33'(0));
            end else begin
                e = pop_exp(id);
                check($sformatf("d%0d_sb_data", id), 33'(od), {1'b0, e});
            end
        end
    endtask

    // Monitor: compare every instance against the model away from the edge.
    always @(negedge clk) begin
        if (started && reset_n === 1'b1) begin
            mon_check(0, bus_a.out_valid, 32'(bus_a.out_data), int'(bus_a.occupancy),
                      int'(tap_sel), bus_a.tap_valid, 32'(bus_a.tap_data));
            mon_check(1, bus_b.out_valid, 32'(bus_b.out_data), int'(bus_b.occupancy),
                      int'(tap_sel), bus_b.tap_valid, 32'(bus_b.tap_data));
            mon_check(2, bus_c.out_valid, bus_c.out_data, int'(bus_c.occupancy),
                      int'(tap_sel_c), bus_c.tap_valid, bus_c.tap_data);
        end
    end

    task automatic step(input bit v, input logic [1:0] d, input logic [31:0] dc,
                        input bit st, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_data_c = dc;
        stall     = st;
        flush     = fl;
        @(posedge clk);
        #1;
        model_edge(v, d, dc, st, fl);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_out_valid"}, 33'(bus_a.out_valid), 33'(0));
        check({tag, "_a_out_data"},  33'(bus_a.out_data),  33'(0));
        check({tag, "_a_occupancy"}, 33'(bus_a.occupancy), 33'(0));
        check({tag, "_a_tap_valid"}, 33'(bus_a.tap_valid), 33'(0));
        check({tag, "_b_out_valid"}, 33'(bus_b.out_valid), 33'(0));
        check({tag, "_b_out_data"},  33'(bus_b.out_data),  33'(0));
        check({tag, "_c_out_valid"}, 33'(bus_c.out_valid), 33'(0));
        check({tag, "_c_out_data"},  33'(bus_c.out_data),  33'(0));
    endtask

    initial begin
        logic [1:0] t1_data [6];
        logic [1:0] tap_exp_d [8];
        bit         tap_exp_v [8];
        logic [31:0] c_word;

        t1_data   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        tap_exp_d = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        tap_exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_data_c = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        tap_sel   = '0;
        tap_sel_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        started = 1'b1;

        // Test 1: consecutive valids, latency of five edges, occupancy ramp.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, t1_data[i], $urandom, 1'b0, 1'b0);
            check("t1_occ", 33'(bus_a.occupancy), 33'((i < 5) ? i + 1 : 5));
            if (i == 3) check("t1_early_valid", 33'(bus_a.out_valid), 33'(0));
            if (i >= 4) begin
                check("t1_out_valid", 33'(bus_a.out_valid), 33'(1));
                check("t1_out_data", 33'(bus_a.out_data), 33'(t1_data[i-4]));
            end
            // Test 5: tap sweep on known contents after the fifth capture.
            if (i == 4) begin
                for (int k = 0; k < 8; k++) begin
                    tap_sel = 3'(k);
                    #1;
                    check("t5_tap_valid", 33'(bus_a.tap_valid), 33'(tap_exp_v[k]));
                    check("t5_tap_data", 33'(bus_a.tap_data), 33'(tap_exp_d[k]));
                end
                tap_sel = '0;
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'd0, $urandom, 1'b0, 1'b0);
            if (i < 4) check("t1_tail_data", 33'(bus_a.out_data), 33'(t1_data[i+2]));
        end

        // Test 2: a stall of three cycles adds exactly three edges of latency.
        for (int e = 1; e <= 8; e++) begin
            if (e == 1)      step(1'b1, 2'd3, $urandom, 1'b0, 1'b0);
            else if (e <= 4) step(1'b1, 2'd1, $urandom, 1'b1, 1'b0);
            else             step(1'b0, 2'd0, $urandom, 1'b0, 1'b0);
            if (e <= 4) check("t2_occ_frozen", 33'(bus_a.occupancy), 33'(1));
            check("t2_out_valid", 33'(bus_a.out_valid), 33'(e == 8));
            if (e == 8) check("t2_out_data", 33'(bus_a.out_data), 33'(3));
        end

        // Test 3: flush wins over stall and drops the simultaneous input.
        for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom), $urandom, 1'b0, 1'b0);
        check("t3_full", 33'(bus_a.occupancy), 33'(5));
        step(1'b1, 2'd3, $urandom, 1'b1, 1'b1);
        check("t3_occ", 33'(bus_a.occupancy), 33'(0));
        check("t3_out_valid", 33'(bus_a.out_valid), 33'(0));
        for (int k = 0; k < 8; k++) begin
            tap_sel = 3'(k);
            #1;
            check("t3_tap_valid", 33'(bus_a.tap_valid), 33'(0));
            check("t3_tap_data", 33'(bus_a.tap_data), 33'(0));
        end
        tap_sel = '0;

        // Test 4: alternating valid, bubbles scrubbed on A but not on B.
        for (int i = 0; i < 12; i++) begin
            step(i % 2 == 0, 2'd2, $urandom, 1'b0, 1'b0);
            if (i >= 4) begin
                check("t4_a_valid", 33'(bus_a.out_valid), 33'((i - 4) % 2 == 0));
                check("t4_a_data", 33'(bus_a.out_data), 33'(((i - 4) % 2 == 0) ? 2 : 0));
                check("t4_b_data", 33'(bus_b.out_data), 33'(2));
            end
        end

        // Test 6: asynchronous reset between edges, then restart.
        for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom), $urandom, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_clear();
        #3 reset_n = 1'b1;
        c_word = $urandom;
        step(1'b1, 2'd1, c_word, 1'b0, 1'b0);
        check("t6_c_valid", 33'(bus_c.out_valid), 33'(1));
        check("t6_c_data", 33'(bus_c.out_data), {1'b0, c_word});
        for (int e = 2; e <= 5; e++) begin
            step(1'b0, 2'd0, $urandom, 1'b0, 1'b0);
            check("t6_out_valid", 33'(bus_a.out_valid), 33'(e == 5));
            if (e == 5) check("t6_out_data", 33'(bus_a.out_data), 33'(1));
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tap_sel   = 3'($urandom_range(0, 7));
            tap_sel_c = 1'($urandom_range(0, 1));
            step($urandom_range(0, 99) < 60, 2'($urandom), $urandom,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
